// File: rtl/alu_pkg.sv
// Shared constants for the button-driven ALU sequencer: opcodes and FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package alu_pkg;

    localparam int STATE_W = 3;
    localparam int OPC_W   = 6;

    // Encoding is visible on o_state, so the values are fixed.
    typedef enum logic [STATE_W-1:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [OPC_W-1:0] OP_ADD = 6'b100000;
    localparam logic [OPC_W-1:0] OP_SUB = 6'b100010;
    localparam logic [OPC_W-1:0] OP_AND = 6'b100100;
    localparam logic [OPC_W-1:0] OP_OR  = 6'b100101;
    localparam logic [OPC_W-1:0] OP_XOR = 6'b100110;
    localparam logic [OPC_W-1:0] OP_NOR = 6'b100111;
    localparam logic [OPC_W-1:0] OP_SRL = 6'b000010;
    localparam logic [OPC_W-1:0] OP_SRA = 6'b000011;

endpackage

// File: rtl/btn_debounce.sv
// Raw button to single-cycle press pulse: 2-flop sync, debounce, rising-edge detect.
// Latency: pulse DEBOUNCE_CYCLES+2 cycles after the first edge that samples the press.
// Backpressure: none; a held button yields one pulse, short bounces yield none.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic             level_d;
    logic [CNT_W-1:0] cnt;

    // Two-flop synchroniser for the asynchronous button.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= i_btn;
            sync2 <= sync1;
        end
    end

    // Debounced level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            level <= 1'b0;
            cnt   <= '0;
        end else if (sync2 != level) begin
            if (cnt == CNT_LAST) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            cnt <= '0;
        end
    end

    // Registered rising-edge detector on the debounced level.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            level_d <= 1'b0;
            o_pulse <= 1'b0;
        end else begin
            level_d <= level;
            o_pulse <= level & ~level_d;
        end
    end

endmodule

// File: rtl/alu_seq_top.sv
// Button-sequenced ALU: load A, B, opcode from switches on debounced presses, then execute.
// Latency: result and o_valid registered two cycles after the opcode press pulse.
// Backpressure: none; presses not expected in the current state are dropped.
module alu_seq_top
    import alu_pkg::*;
#(
    parameter int NB_DATA         = 8,
    parameter int NB_OP           = 6,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_switches,
    input  logic               i_btn_a,
    input  logic               i_btn_b,
    input  logic               i_btn_op,
    output logic [NB_DATA-1:0] o_res,
    output logic               o_carry,
    output logic               o_zero,
    output logic               o_err,
    output logic               o_valid,
    output logic [STATE_W-1:0] o_state
);

    localparam int SH_W = $clog2(NB_DATA);

    localparam logic [NB_OP-1:0] C_ADD = NB_OP'(OP_ADD);
    localparam logic [NB_OP-1:0] C_SUB = NB_OP'(OP_SUB);
    localparam logic [NB_OP-1:0] C_AND = NB_OP'(OP_AND);
    localparam logic [NB_OP-1:0] C_OR  = NB_OP'(OP_OR);
    localparam logic [NB_OP-1:0] C_XOR = NB_OP'(OP_XOR);
    localparam logic [NB_OP-1:0] C_NOR = NB_OP'(OP_NOR);
    localparam logic [NB_OP-1:0] C_SRL = NB_OP'(OP_SRL);
    localparam logic [NB_OP-1:0] C_SRA = NB_OP'(OP_SRA);

    logic pulse_a, pulse_b, pulse_op;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_a (
        .i_clk(i_clk), .i_reset(i_reset), .i_btn(i_btn_a), .o_pulse(pulse_a));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_b (
        .i_clk(i_clk), .i_reset(i_reset), .i_btn(i_btn_b), .o_pulse(pulse_b));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_op (
        .i_clk(i_clk), .i_reset(i_reset), .i_btn(i_btn_op), .o_pulse(pulse_op));

    state_t             state, state_nxt;
    logic               load_a, load_b, load_op, exec_en, clr_valid;
    logic [NB_DATA-1:0] a_q, b_q;
    logic [NB_OP-1:0]   op_q;

    logic [NB_DATA:0]   sum, diff;
    logic [NB_DATA-1:0] alu_res;
    logic               alu_carry, alu_err;

    // State register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state <= WAIT_A;
        else         state <= state_nxt;
    end

    // Next state and load strobes; only the press expected in a state has any effect.
    always_comb begin
        state_nxt = state;
        load_a    = 1'b0;
        load_b    = 1'b0;
        load_op   = 1'b0;
        exec_en   = 1'b0;
        clr_valid = 1'b0;
        case (state)
            WAIT_A:  if (pulse_a)  begin load_a  = 1'b1; state_nxt = WAIT_B;  end
            WAIT_B:  if (pulse_b)  begin load_b  = 1'b1; state_nxt = WAIT_OP; end
            WAIT_OP: if (pulse_op) begin load_op = 1'b1; state_nxt = EXEC;    end
            EXEC:    begin exec_en = 1'b1; state_nxt = DONE; end
            DONE:    if (pulse_a) begin
                load_a    = 1'b1;
                clr_valid = 1'b1;
                state_nxt = WAIT_B;
            end
            default: state_nxt = WAIT_A;
        endcase
    end

    // Operand and opcode capture from the switches.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= '0;
        end else begin
            if (load_a)  a_q  <= i_switches;
            if (load_b)  b_q  <= i_switches;
            if (load_op) op_q <= i_switches[NB_OP-1:0];
        end
    end

    assign sum  = {1'b0, a_q} + {1'b0, b_q};
    // The extra top bit of the difference is set exactly when A < B unsigned.
    assign diff = {1'b0, a_q} - {1'b0, b_q};

    // Combinational ALU on the captured operands.
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_err   = 1'b0;
        case (op_q)
            C_ADD: begin alu_res = sum[NB_DATA-1:0];  alu_carry = sum[NB_DATA];  end
            C_SUB: begin alu_res = diff[NB_DATA-1:0]; alu_carry = diff[NB_DATA]; end
            C_AND: alu_res = a_q & b_q;
            C_OR:  alu_res = a_q | b_q;
            C_XOR: alu_res = a_q ^ b_q;
            C_NOR: alu_res = ~(a_q | b_q);
            C_SRL: alu_res = a_q >> b_q[SH_W-1:0];
            C_SRA: alu_res = $unsigned($signed(a_q) >>> b_q[SH_W-1:0]);
            default: alu_err = 1'b1;
        endcase
    end

    // Result registers update only in EXEC; a new A press just drops o_valid.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_res   <= '0;
            o_carry <= 1'b0;
            o_zero  <= 1'b0;
            o_err   <= 1'b0;
            o_valid <= 1'b0;
        end else if (exec_en) begin
            o_res   <= alu_res;
            o_carry <= alu_carry;
            o_zero  <= (alu_res == '0);
            o_err   <= alu_err;
            o_valid <= 1'b1;
        end else if (clr_valid) begin
            o_valid <= 1'b0;
        end
    end

    assign o_state = state;

endmodule

// File: tb/tb_alu_seq_top.sv
module tb_alu_seq_top;

    localparam int DB = 4;

    localparam logic [5:0] ADD = 6'b100000, SUB = 6'b100010, AND_ = 6'b100100,
                           OR_ = 6'b100101, XOR_ = 6'b100110, NOR_ = 6'b100111,
                           SRL = 6'b000010, SRA = 6'b000011;

    localparam logic [2:0] S_WA = 3'd0, S_WB = 3'd1, S_WOP = 3'd2, S_EX = 3'd3, S_DONE = 3'd4;

    typedef struct {
        logic [7:0] res;
        logic       c;
        logic       z;
        logic       e;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] sw;
    logic [2:0] btn;
    logic [7:0] o_res;
    logic       o_carry, o_zero, o_err, o_valid;
    logic [2:0] o_state;

    int n_pass  = 0;
    int n_total = 0;
    int w_trans;
    logic [2:0] w_prev;

    always #5 clk = ~clk;

    alu_seq_top #(.NB_DATA(8), .NB_OP(6), .DEBOUNCE_CYCLES(DB)) dut (
        .i_clk(clk), .i_reset(rst), .i_switches(sw),
        .i_btn_a(btn[0]), .i_btn_b(btn[1]), .i_btn_op(btn[2]),
        .o_res(o_res), .o_carry(o_carry), .o_zero(o_zero), .o_err(o_err),
        .o_valid(o_valid), .o_state(o_state)
    );

    // Reference ALU from the opcode table, using plain integer arithmetic.
    function automatic exp_t model(input int a, input int b, input logic [5:0] op);
        exp_t e;
        int   r, sa, sh;
        r = 0; e.c = 1'b0; e.e = 1'b0; sh = b % 8;
        case (op)
            ADD:  begin r = a + b; e.c = (r > 255); end
            SUB:  begin r = a - b; e.c = (a < b); if (r < 0) r = r + 256; end
            AND_: r = a & b;
            OR_:  r = a | b;
            XOR_: r = a ^ b;
            NOR_: r = ~(a | b);
            SRL:  r = a / (1 << sh);
            SRA:  begin sa = (a >= 128) ? a - 256 : a; r = sa >>> sh; end
            default: begin r = 0; e.e = 1'b1; end
        endcase
        r     = r & 255;
        e.res = r[7:0];
        e.z   = (r == 0);
        return e;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick_watch(input int n);
        repeat (n) begin
            @(negedge clk);
            if (o_state !== w_prev) begin
                w_trans++;
                w_prev = o_state;
            end
        end
    endtask

    task automatic press(input int which, input logic [7:0] v);
        sw = v;
        btn[which] = 1'b1;
        tick(DB + 6);
        btn[which] = 1'b0;
        tick(DB + 4);
    endtask

    task automatic do_seq(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        press(0, a);
        press(1, b);
        press(2, {2'b00, op});
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_reset();
        rst = 1'b1; btn = 3'b000; sw = 8'h00;
        tick(2);
        n_total++; if (o_state !== S_WA) $display("FAIL reset_state got %0d want %0d", o_state, S_WA); else n_pass++;
        n_total++; if ({o_res, o_carry, o_zero, o_err, o_valid} !== 12'h000)
            $display("FAIL reset_outputs got %h want 000", {o_res, o_carry, o_zero, o_err, o_valid}); else n_pass++;
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_add_timing();
        press(0, 8'h7F);
        press(1, 8'h01);
        sw = 8'h20; btn[2] = 1'b1;
        tick(DB + 4);
        n_total++; if (o_state !== S_EX || o_valid !== 1'b0)
            $display("FAIL exec_cycle got state %0d valid %b want %0d 0", o_state, o_valid, S_EX); else n_pass++;
        tick(1);
        n_total++; if (o_state !== S_DONE || o_valid !== 1'b1)
            $display("FAIL valid_rise got state %0d valid %b want %0d 1", o_state, o_valid, S_DONE); else n_pass++;
        n_total++; if ({o_res, o_carry, o_zero, o_err} !== {8'h80, 3'b000})
            $display("FAIL add_7f_01 got %h %b%b%b want 80 000", o_res, o_carry, o_zero, o_err); else n_pass++;
        btn[2] = 1'b0;
        tick(DB + 4);
    endtask

    task automatic test_sub_add();
        do_seq(8'h03, 8'h05, SUB);
        n_total++; if ({o_res, o_carry, o_zero} !== {8'hFE, 2'b10})
            $display("FAIL sub_03_05 got %h c%b z%b want fe c1 z0", o_res, o_carry, o_zero); else n_pass++;
        do_seq(8'hFF, 8'h01, ADD);
        n_total++; if ({o_res, o_carry, o_zero, o_valid} !== {8'h00, 3'b111})
            $display("FAIL add_ff_01 got %h c%b z%b v%b want 00 c1 z1 v1", o_res, o_carry, o_zero, o_valid); else n_pass++;
    endtask

    task automatic test_bounce();
        int cyc, hi, lo;
        apply_reset();
        w_trans = 0; w_prev = o_state; cyc = 0;
        sw = 8'h5A;
        while (cyc < 20) begin
            hi = $urandom_range(1, 2);
            lo = $urandom_range(1, 2);
            btn[0] = 1'b1; tick_watch(hi);
            btn[0] = 1'b0; tick_watch(lo);
            cyc = cyc + hi + lo;
        end
        n_total++; if (w_trans !== 0) $display("FAIL bounce_ignored got %0d transitions want 0", w_trans); else n_pass++;
        btn[0] = 1'b1; tick_watch(10);
        btn[0] = 1'b0; tick_watch(DB + 4);
        n_total++; if (w_trans !== 1 || o_state !== S_WB)
            $display("FAIL bounce_one_load got %0d transitions state %0d want 1 %0d", w_trans, o_state, S_WB); else n_pass++;
        press(1, 8'h00);
        press(2, {2'b00, ADD});
        n_total++; if (o_res !== 8'h5A) $display("FAIL bounce_a_value got %h want 5a", o_res); else n_pass++;
    endtask

    task automatic test_ignore();
        press(0, 8'h21);
        press(2, {2'b00, ADD});
        press(0, 8'h55);
        n_total++; if (o_state !== S_WB) $display("FAIL ignore_in_wait_b got %0d want %0d", o_state, S_WB); else n_pass++;
        press(1, 8'h02);
        n_total++; if (o_state !== S_WOP) $display("FAIL b_after_ignore got %0d want %0d", o_state, S_WOP); else n_pass++;
        press(2, {2'b00, ADD});
        n_total++; if (o_res !== 8'h23) $display("FAIL a_unchanged got %h want 23", o_res); else n_pass++;
        // Simultaneous A and B presses in DONE: only A is consumed.
        sw = 8'h10; btn = 3'b011;
        tick(DB + 6);
        btn = 3'b000;
        tick(DB + 4);
        n_total++; if (o_state !== S_WB || o_valid !== 1'b0 || o_res !== 8'h23)
            $display("FAIL simultaneous got state %0d valid %b res %h want %0d 0 23", o_state, o_valid, o_res, S_WB); else n_pass++;
        press(1, 8'h01);
        press(2, {2'b00, ADD});
        n_total++; if (o_res !== 8'h11) $display("FAIL simultaneous_result got %h want 11", o_res); else n_pass++;
    endtask

    task automatic test_shift_err();
        do_seq(8'h80, 8'h03, SRA);
        n_total++; if ({o_res, o_carry, o_err} !== {8'hF0, 2'b00})
            $display("FAIL sra got %h c%b e%b want f0 c0 e0", o_res, o_carry, o_err); else n_pass++;
        do_seq(8'h80, 8'h03, SRL);
        n_total++; if ({o_res, o_carry, o_err} !== {8'h10, 2'b00})
            $display("FAIL srl got %h c%b e%b want 10 c0 e0", o_res, o_carry, o_err); else n_pass++;
        do_seq(8'h80, 8'h03, 6'h3F);
        n_total++; if ({o_res, o_carry, o_zero, o_err} !== {8'h00, 3'b011})
            $display("FAIL bad_opcode got %h c%b z%b e%b want 00 c0 z1 e1", o_res, o_carry, o_zero, o_err); else n_pass++;
    endtask

    task automatic test_random();
        logic [5:0] ops [9];
        logic [7:0] a, b;
        logic [5:0] op;
        exp_t       e;
        ops = '{ADD, SUB, AND_, OR_, XOR_, NOR_, SRL, SRA, 6'h00};
        for (int i = 0; i < 10; i++) begin
            a  = 8'($urandom_range(0, 255));
            b  = 8'($urandom_range(0, 255));
            op = ops[$urandom_range(0, 8)];
            if (op == 6'h00) op = 6'($urandom_range(0, 63));
            do_seq(a, b, op);
            e = model(int'(a), int'(b), op);
            n_total++; if ({o_res, o_carry, o_zero, o_err, o_valid} !== {e.res, e.c, e.z, e.e, 1'b1})
                $display("FAIL random_%0d a=%h b=%h op=%b got %h c%b z%b e%b v%b want %h c%b z%b e%b v1",
                         i, a, b, op, o_res, o_carry, o_zero, o_err, o_valid, e.res, e.c, e.z, e.e);
            else n_pass++;
        end
    endtask

    task automatic test_reset_async();
        do_seq(8'h12, 8'h01, ADD);
        press(0, 8'h40);
        press(1, 8'h40);
        n_total++; if (o_state !== S_WOP || o_res !== 8'h13 || o_valid !== 1'b0)
            $display("FAIL pre_reset got state %0d res %h valid %b want %0d 13 0", o_state, o_res, o_valid, S_WOP); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++; if (o_state !== S_WA || {o_res, o_carry, o_zero, o_err, o_valid} !== 12'h000)
            $display("FAIL async_reset got state %0d outs %h want 0 000", o_state, {o_res, o_carry, o_zero, o_err, o_valid}); else n_pass++;
        // Button held through reset release: full sync + debounce delay before the load.
        sw = 8'h11; btn[0] = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(DB + 3);
        n_total++; if (o_state !== S_WA) $display("FAIL held_btn_early got %0d want %0d", o_state, S_WA); else n_pass++;
        tick(1);
        n_total++; if (o_state !== S_WB) $display("FAIL held_btn_load got %0d want %0d", o_state, S_WB); else n_pass++;
        btn[0] = 1'b0;
        tick(DB + 4);
        press(1, 8'h22);
        n_total++; if (o_valid !== 1'b0) $display("FAIL no_stale_result got valid %b want 0", o_valid); else n_pass++;
        press(2, {2'b00, ADD});
        n_total++; if (o_res !== 8'h33 || o_valid !== 1'b1)
            $display("FAIL post_reset_seq got %h v%b want 33 v1", o_res, o_valid); else n_pass++;
    endtask

    initial begin
        rst = 1'b1; btn = 3'b000; sw = 8'h00;
        test_reset();
        test_add_timing();
        test_sub_add();
        test_bounce();
        test_ignore();
        test_shift_err();
        test_random();
        test_reset_async();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_seq_top.md
ALU_SEQ_TOP -- requirements
Module: alu_seq_top

Interface
REQ-001 The block SHALL have parameter NB_DATA, default 8, meaning the operand and result width in bits (minimum 4).
REQ-002 The block SHALL have parameter NB_OP, default 6, meaning the opcode width in bits (NB_OP <= NB_DATA).
REQ-003 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning the consecutive stable-high cycles required to accept a button press (minimum 1).
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-005 i_clk  in  1  clock; all state updates on the rising edge.
REQ-006 i_reset  in  1  asynchronous, active-high reset.
REQ-007 i_switches  in  NB_DATA  operand/opcode value; opcode uses bits [NB_OP-1:0].
REQ-008 i_btn_a, i_btn_b, i_btn_op  in  1 each  raw, asynchronous, bouncing buttons.
REQ-009 o_res  out  NB_DATA  registered ALU result.
REQ-010 o_carry  out  1  registered carry (ADD) or borrow (SUB), else 0.
REQ-011 o_zero  out  1  registered flag, 1 when o_res is zero.
REQ-012 o_err  out  1  registered flag, 1 when the executed opcode is unsupported.
REQ-013 o_valid  out  1  1 while o_res, o_carry, o_zero and o_err hold a completed result.
REQ-014 o_state  out  3  current FSM state encoding, for LEDs and debug.

Function
REQ-015 Each button SHALL pass through a two-flop synchroniser, then a debouncer, then a rising-edge detector.
  - Debouncer: output rises after DEBOUNCE_CYCLES consecutive synchronised-high samples and falls after DEBOUNCE_CYCLES consecutive lows.
  - Edge detector: one-cycle pulse per accepted press.
REQ-016 A raw press held stable SHALL produce its pulse exactly DEBOUNCE_CYCLES+2 cycles after the first rising edge that samples it high.
REQ-017 Bounces shorter than DEBOUNCE_CYCLES SHALL produce no pulse, and a held button SHALL produce exactly one pulse.
REQ-018 FSM states: WAIT_A=0, WAIT_B=1, WAIT_OP=2, EXEC=3, DONE=4.
REQ-019 WAIT_A SHALL load A from i_switches on an A pulse and go to WAIT_B.
REQ-020 WAIT_B SHALL load B from i_switches on a B pulse and go to WAIT_OP.
REQ-021 WAIT_OP SHALL load the opcode from i_switches[NB_OP-1:0] on an OP pulse and go to EXEC.
REQ-022 EXEC SHALL last one cycle, register the result and flags, and go to DONE; o_valid rises on the cycle after EXEC (two cycles after the OP pulse).
REQ-023 In DONE, an A pulse SHALL load the new A, clear o_valid, and go to WAIT_B, while o_res keeps its last value.
REQ-024 A pulse from a button not expected in the current state SHALL be ignored; on simultaneous pulses only the expected one acts.
REQ-025 Opcodes: ADD=100000, SUB=100010, AND=100100, OR=100101, XOR=100110, NOR=100111, SRL=000010, SRA=000011.
REQ-026 ADD SHALL give o_carry = bit NB_DATA of the (NB_DATA+1)-bit sum.
REQ-027 SUB SHALL give A-B modulo 2^NB_DATA, with o_carry=1 iff A<B unsigned.
REQ-028 SRL and SRA SHALL shift A right by B[$clog2(NB_DATA)-1:0] (SRA sign-fills), with o_carry=0.
REQ-029 An unsupported opcode SHALL give o_res=0, o_carry=0, o_zero=1 and o_err=1; o_err=0 for every supported opcode.

Reset
REQ-030 Asserting i_reset at any time SHALL immediately force state WAIT_A and clear A, B, the opcode, o_res, o_carry, o_zero, o_err, o_valid, the synchronisers, the debouncers and the edge detectors to 0.
REQ-031 A reset asserted mid-sequence (WAIT_B, WAIT_OP or EXEC) SHALL discard the partial loads and register no result.
REQ-032 After reset release, a button already held high SHALL produce its pulse only after the full synchroniser and debounce delay.

Structure
REQ-033 A shared package alu_pkg SHALL hold the opcode constants, the state encoding and the state width.
REQ-034 Synchroniser, debouncer and edge detector SHALL form sub-module btn_debounce, instantiated three times.
REQ-035 The ALU datapath SHALL be combinational inside alu_seq_top, registered only in EXEC.

Verification
REQ-036 Defaults; A=0x7F, B=0x01, op ADD, each button clean -> o_res=0x80, o_carry=0, o_zero=0, o_valid=1 two cycles after the OP pulse.
REQ-037 A=0x03, B=0x05, SUB -> o_res=0xFE, o_carry=1; then A=0xFF, B=0x01, ADD -> o_res=0x00, o_carry=1, o_zero=1.
REQ-038 i_btn_a bouncing 1-2-cycle glitches for 20 cycles, then held 10 cycles -> exactly one load and WAIT_A->WAIT_B once.
REQ-039 In WAIT_B, pulse OP and then A -> state stays WAIT_B and A is unchanged; a following B press then advances normally.
REQ-040 A=0x80, B=0x03, SRA -> 0xF0; SRL -> 0x10; opcode 0x3F -> o_res=0, o_err=1.
REQ-041 Assert i_reset in WAIT_OP -> outputs 0 and o_state=WAIT_A asynchronously (before the next clock edge).
